// File: rtl/ped_crossing_if.sv
// Push-button and lamp/status bundle of the pedestrian-crossing controller.
// The master side is the button panel / supervisor; the slave side is the controller.
interface ped_crossing_if #(
   parameter int NUM_REQ = 2
) ();
   logic [NUM_REQ-1:0] ped_req;
   logic               veh_stop;
   logic               ped_red;
   logic               ped_yellow;
   logic               ped_green;
   logic               req_pending;
   logic [2:0]         state;

   modport master (
      output ped_req,
      input  veh_stop, ped_red, ped_yellow, ped_green, req_pending, state
   );

   modport slave (
      input  ped_req,
      output veh_stop, ped_red, ped_yellow, ped_green, req_pending, state
   );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing phase controller: IDLE -> STOP -> WALK -> CLEAR -> GAP, tick-timed.
// Optional build macro PED_FLASH_EN makes the clearance lamp flash instead of staying steady.
module ped_crossing_ctrl #(
   parameter int CLK_PER_TICK  = 4,
   parameter int STOP_TICKS    = 2,
   parameter int WALK_TICKS    = 5,
   parameter int CLEAR_TICKS   = 2,
   parameter int MIN_GAP_TICKS = 3,
   parameter int NUM_REQ       = 2,
   parameter int CNT_W         = 8,
   parameter int PRE_W         = 16
) (
   input logic           clk,
   input logic           reset,
   ped_crossing_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      STOP  = 3'd1,
      WALK  = 3'd2,
      CLEAR = 3'd3,
      GAP   = 3'd4
   } state_t;

   localparam int GAP_D = (MIN_GAP_TICKS > 0) ? MIN_GAP_TICKS : 1;
   localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLK_PER_TICK - 1);
   localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_TICKS - 1);
   localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_TICKS - 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_D - 1);

   state_t             state_q, state_d;
   logic [PRE_W-1:0]   pre_q;
   logic [CNT_W-1:0]   tmr_q;
   logic               latch_q, latch_d;
   logic               tick;
   logic               entering;
   logic               yel_on;
   logic [NUM_REQ-1:0] req_s;

   assign req_s    = bus.ped_req;
   assign tick     = (pre_q == PRE_LAST);
   assign entering = (state_d != state_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (latch_q) state_d = STOP;
         STOP:  if (tick && tmr_q == STOP_LAST) state_d = WALK;
         WALK:  if (tick && tmr_q == WALK_LAST) state_d = CLEAR;
         CLEAR: if (tick && tmr_q == CLEAR_LAST) state_d = (MIN_GAP_TICKS > 0) ? GAP : IDLE;
         GAP:   if (tick && tmr_q == GAP_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Clearing on WALK entry wins over a press sampled on that same edge.
   assign latch_d = (state_q == STOP && state_d == WALK) ? 1'b0 : (latch_q | (|req_s));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pre_q   <= '0;
         tmr_q   <= '0;
         latch_q <= 1'b0;
      end else begin
         state_q <= state_d;
         latch_q <= latch_d;
         if (entering || state_q == IDLE) begin
            pre_q <= '0;
            tmr_q <= '0;
         end else if (tick) begin
            pre_q <= '0;
            tmr_q <= tmr_q + 1'b1;
         end else begin
            pre_q <= pre_q + 1'b1;
         end
      end
   end

`ifdef PED_FLASH_EN
   logic flash_q;

   // Yellow is lit on CLEAR entry and inverts on every tick while in CLEAR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flash_q <= 1'b1;
      end else if (state_d == CLEAR && state_q != CLEAR) begin
         flash_q <= 1'b1;
      end else if (state_q == CLEAR && tick) begin
         flash_q <= ~flash_q;
      end
   end

   assign yel_on = flash_q;
`else
   assign yel_on = 1'b1;
`endif

   logic veh_stop_c, ped_red_c, ped_yellow_c, ped_green_c;

   always_comb begin
      veh_stop_c   = 1'b0;
      ped_red_c    = 1'b1;
      ped_yellow_c = 1'b0;
      ped_green_c  = 1'b0;
      case (state_q)
         STOP: veh_stop_c = 1'b1;
         WALK: begin
            veh_stop_c  = 1'b1;
            ped_red_c   = 1'b0;
            ped_green_c = 1'b1;
         end
         CLEAR: begin
            veh_stop_c   = 1'b1;
            ped_red_c    = 1'b0;
            ped_yellow_c = yel_on;
         end
         default: ;
      endcase
   end

   assign bus.veh_stop    = veh_stop_c;
   assign bus.ped_red     = ped_red_c;
   assign bus.ped_yellow  = ped_yellow_c;
   assign bus.ped_green   = ped_green_c;
   assign bus.req_pending = latch_q;
   assign bus.state       = state_q;
endmodule
